// File: rtl/debug_run_controller.sv
// Run/step/pause sequencer between the UART debug link and the MIPS pipeline.
// Decodes host command bytes, freezes the pipeline on every stop and streams a
// fixed dump (PC, stage latches, register file, data memory) MSB first over the
// UART transmitter.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   rx_done, rx_data      received command byte strobe and value
//   in_halt               halt instruction has reached write-back (level)
//   inPC                  current PC
//   inLatch               latch word selected by outControlLatchMux
//   inFRData, inMemData   RF / data-memory word at outDebugAddress
//   tx_done               UART byte finished (pulse)
//   tx_start, tx_data     send request (pulse) and byte to transmit
//   stop_debug            1 = pipeline frozen
//   debug_on              1 = RF/memory read ports driven by outDebugAddress
//   outControlLatchMux    latch select
//   outDebugAddress       RF/memory debug word address
//   busy                  1 whenever the sequencer is not idle
module debug_run_controller #(
    parameter int unsigned NUM_LATCH = 40,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_MEM   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        in_halt,
    input  logic [31:0] inPC,
    input  logic [31:0] inLatch,
    input  logic [31:0] inFRData,
    input  logic [31:0] inMemData,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        stop_debug,
    output logic        debug_on,
    output logic [6:0]  outControlLatchMux,
    output logic [31:0] outDebugAddress,
    output logic        busy
);

    localparam int unsigned NUM_WORDS = 1 + NUM_LATCH + NUM_REGS + NUM_MEM;
    localparam int unsigned WORD_W    = $clog2(NUM_WORDS);
    localparam int unsigned REG_BASE  = 1 + NUM_LATCH;
    localparam int unsigned MEM_BASE  = REG_BASE + NUM_REGS;
    localparam int unsigned LAST_WORD = NUM_WORDS - 1;

    localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
    localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        SELECT  = 3'd3,
        SETTLE  = 3'd4,
        SEND    = 3'd5,
        WAIT_TX = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic                halted_q, halted_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [1:0]          byte_q, byte_d;
    logic [31:0]         shreg_q, shreg_d;
    logic                stop_debug_q, stop_debug_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                debug_on_q, debug_on_d;
    logic [6:0]          mux_q, mux_d;
    logic [31:0]         addr_q, addr_d;
    logic                busy_q, busy_d;

    // Which section of the dump the current word belongs to.
    logic is_pc, is_latch, is_reg, is_mem;
    assign is_pc    = (word_q == '0);
    assign is_latch = !is_pc && (word_q < WORD_W'(REG_BASE));
    assign is_reg   = (word_q >= WORD_W'(REG_BASE)) && (word_q < WORD_W'(MEM_BASE));
    assign is_mem   = (word_q >= WORD_W'(MEM_BASE));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            halted_q     <= 1'b0;
            word_q       <= '0;
            byte_q       <= '0;
            shreg_q      <= '0;
            stop_debug_q <= 1'b1;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            debug_on_q   <= 1'b0;
            mux_q        <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            word_q       <= word_d;
            byte_q       <= byte_d;
            shreg_q      <= shreg_d;
            stop_debug_q <= stop_debug_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            debug_on_q   <= debug_on_d;
            mux_q        <= mux_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        word_d       = word_q;
        byte_d       = byte_q;
        shreg_d      = shreg_q;
        stop_debug_d = stop_debug_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        debug_on_d   = debug_on_q;
        mux_d        = mux_q;
        addr_d       = addr_q;

        unique case (state_q)
            IDLE: begin
                stop_debug_d = 1'b1;
                if (rx_done) begin
                    case (rx_data)
                        CMD_RUN: if (!halted_q) begin
                            state_d      = RUN;
                            stop_debug_d = 1'b0;
                        end
                        CMD_STEP: if (!halted_q) begin
                            state_d      = STEP;
                            stop_debug_d = 1'b0;
                        end
                        CMD_DUMP: begin
                            state_d = SELECT;
                            word_d  = '0;
                            byte_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end

            // A simultaneous halt and pause both funnel into the one exit path.
            RUN: begin
                if (in_halt) halted_d = 1'b1;
                if (in_halt || (rx_done && rx_data == CMD_PAUSE)) begin
                    state_d      = SELECT;
                    stop_debug_d = 1'b1;
                    word_d       = '0;
                    byte_d       = '0;
                end else begin
                    stop_debug_d = 1'b0;
                end
            end

            // Pipeline was released for exactly this one cycle.
            STEP: begin
                if (in_halt) halted_d = 1'b1;
                stop_debug_d = 1'b1;
                state_d      = SELECT;
                word_d       = '0;
                byte_d       = '0;
            end

            SELECT: begin
                mux_d      = is_latch ? 7'(word_q - WORD_W'(1)) : 7'd0;
                debug_on_d = is_reg || is_mem;
                if (is_reg)      addr_d = 32'(word_q - WORD_W'(REG_BASE));
                else if (is_mem) addr_d = 32'(word_q - WORD_W'(MEM_BASE));
                else             addr_d = '0;
                state_d = SETTLE;
            end

            // Select/address outputs have been stable for a full cycle here.
            SETTLE: begin
                if (is_pc)         shreg_d = inPC;
                else if (is_latch) shreg_d = inLatch;
                else if (is_reg)   shreg_d = inFRData;
                else               shreg_d = inMemData;
                byte_d  = '0;
                state_d = SEND;
            end

            SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = shreg_q[31:24];
                state_d    = WAIT_TX;
            end

            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_q == 2'd3) begin
                        byte_d = '0;
                        if (word_q == WORD_W'(LAST_WORD)) begin
                            word_d     = '0;
                            debug_on_d = 1'b0;
                            mux_d      = '0;
                            addr_d     = '0;
                            state_d    = IDLE;
                        end else begin
                            word_d  = word_q + WORD_W'(1);
                            state_d = SELECT;
                        end
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = {shreg_q[23:0], 8'h00};
                        state_d = SEND;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_start           = tx_start_q;
    assign tx_data            = tx_data_q;
    assign stop_debug         = stop_debug_q;
    assign debug_on           = debug_on_q;
    assign outControlLatchMux = mux_q;
    assign outDebugAddress    = addr_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: directed command sequence with randomized
// latch/RF/memory contents, UART handshake delays and stray command bytes.
module tb_debug_run_controller;

    localparam int unsigned NL     = 40;
    localparam int unsigned NR     = 32;
    localparam int unsigned NM     = 32;
    localparam int unsigned NBYTES = 4 * (1 + NL + NR + NM);
    localparam int          BUDGET = 10000;

    logic        clk;
    logic        rst;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        in_halt;
    logic [31:0] inPC;
    logic [31:0] inLatch;
    logic [31:0] inFRData;
    logic [31:0] inMemData;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        stop_debug;
    logic        debug_on;
    logic [6:0]  mux;
    logic [31:0] addr;
    logic        busy;

    logic [31:0] latch_tab [128];
    logic [31:0] rf_tab    [32];
    logic [31:0] mem_tab   [32];

    // Environment: latch mux and debug read ports answer combinationally.
    assign inLatch   = latch_tab[mux];
    assign inFRData  = debug_on ? rf_tab[addr[4:0]]  : 32'hDEAD_BEEF;
    assign inMemData = debug_on ? mem_tab[addr[4:0]] : 32'hBAD0_BAD0;

    debug_run_controller #(.NUM_LATCH(NL), .NUM_REGS(NR), .NUM_MEM(NM)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_done            (rx_done),
        .rx_data            (rx_data),
        .in_halt            (in_halt),
        .inPC               (inPC),
        .inLatch            (inLatch),
        .inFRData           (inFRData),
        .inMemData          (inMemData),
        .tx_done            (tx_done),
        .tx_start           (tx_start),
        .tx_data            (tx_data),
        .stop_debug         (stop_debug),
        .debug_on           (debug_on),
        .outControlLatchMux (mux),
        .outDebugAddress    (addr),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART transmitter model: answers each tx_start with tx_done after 0..3 cycles.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    int         checks;
    int         errors;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         dump_base;
    int         low_cycles;
    int         bad_tx;
    bit         mux_seen [128];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock; observe outputs at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (tx_start === 1'b1) begin
            got.push_back(tx_data);
            if (stop_debug !== 1'b1 || busy !== 1'b1) bad_tx++;
        end
        if (stop_debug === 1'b0) low_cycles++;
        mux_seen[mux] = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
        tick();
    endtask

    function automatic logic [7:0] pick_cmd();
        case ($urandom_range(0, 4))
            0:       return 8'h63;
            1:       return 8'h73;
            2:       return 8'h64;
            3:       return 8'h70;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic fill_tables(input bit fixed_rf);
        for (int i = 0; i < 128; i++) latch_tab[i] = $urandom;
        for (int i = 0; i < 32; i++) begin
            rf_tab[i]  = fixed_rf ? 32'h1111_1111 : $urandom;
            mem_tab[i] = $urandom;
        end
    endtask

    // Wait for the sequencer to return idle; optionally throw stray commands at it.
    task automatic wait_idle(input string tag, input bit inject);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            rx_done = 1'b0;
            if (inject && busy === 1'b1 && got.size() > dump_base &&
                $urandom_range(0, 39) == 0) begin
                rx_data = pick_cmd();
                rx_done = 1'b1;
            end
            tick();
            n++;
        end
        rx_done = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Dump contents are the PC, every latch, every register, every memory word.
    task automatic check_dump(input string tag);
        int mism;
        exp_q = {};
        push_word(inPC);
        for (int k = 0; k < int'(NL); k++) push_word(latch_tab[k]);
        for (int r = 0; r < int'(NR); r++) push_word(rf_tab[r]);
        for (int m = 0; m < int'(NM); m++) push_word(mem_tab[m]);
        mism = 0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (dump_base + i >= got.size()) mism++;
            else if (got[dump_base + i] !== exp_q[i]) mism++;
        end
        check({tag, "_len"},      32'(got.size() - dump_base), 32'(NBYTES));
        check({tag, "_data"},     32'(mism), 32'd0);
        check({tag, "_txflags"},  32'(bad_tx), 32'd0);
        check({tag, "_stop"},     32'(stop_debug), 32'd1);
        check({tag, "_dbg_off"},  32'(debug_on), 32'd0);
        check({tag, "_mux0"},     32'(mux), 32'd0);
        check({tag, "_addr0"},    addr, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stop"},   32'(stop_debug), 32'd1);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_txs"},    32'(tx_start), 32'd0);
        check({tag, "_txd"},    32'(tx_data), 32'd0);
        check({tag, "_dbg"},    32'(debug_on), 32'd0);
        check({tag, "_mux"},    32'(mux), 32'd0);
        check({tag, "_addr"},   addr, 32'd0);
    endtask

    initial begin
        int n;
        int lo;
        int hi;
        int low0;
        logic [7:0] b;
        checks = 0; errors = 0; dump_base = 0; low_cycles = 0; bad_tx = 0;
        rx_done = 1'b0; rx_data = 8'h00; in_halt = 1'b0; inPC = 32'h0;
        fill_tables(1'b1);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(); tick();

        // Dump with no run; fixed PC and register contents.
        inPC = 32'h0040_0010;
        dump_base = got.size();
        send_rx(8'h64);
        wait_idle("dumpA", 1'b1);
        check_dump("dumpA");
        for (int k = 0; k < 4; k++) begin
            b = (dump_base + k < got.size()) ? got[dump_base + k] : 8'hxx;
            case (k)
                0: check("dumpA_b0", 32'(b), 32'h00);
                1: check("dumpA_b1", 32'(b), 32'h40);
                2: check("dumpA_b2", 32'(b), 32'h00);
                default: check("dumpA_b3", 32'(b), 32'h10);
            endcase
        end

        // Single step: pipeline released for one clock, then full dump.
        fill_tables(1'b0);
        inPC = $urandom;
        for (int i = 0; i < 128; i++) mux_seen[i] = 1'b0;
        low0 = low_cycles;
        dump_base = got.size();
        send_rx(8'h73);
        wait_idle("dumpB", 1'b1);
        check_dump("dumpB");
        check("step_low_cycles", 32'(low_cycles - low0), 32'd1);
        lo = 0; hi = 0;
        for (int i = 0; i < 128; i++) begin
            if (mux_seen[i] && i < int'(NL)) lo++;
            if (mux_seen[i] && i >= int'(NL)) hi++;
        end
        check("mux_sweep_in",  32'(lo), 32'(NL));
        check("mux_sweep_out", 32'(hi), 32'd0);

        // Run until halt; afterwards 'c' is ignored but 'd' still dumps.
        fill_tables(1'b0);
        inPC = $urandom;
        dump_base = got.size();
        send_rx(8'h63);
        repeat (50) tick();
        check("run_low", 32'(stop_debug), 32'd0);
        in_halt = 1'b1;
        @(posedge clk);
        #1;
        check("halt_edge_stop", 32'(stop_debug), 32'd1);
        wait_idle("dumpC", 1'b1);
        check_dump("dumpC");
        send_rx(8'h63);
        repeat (10) tick();
        check("halted_c_stop", 32'(stop_debug), 32'd1);
        check("halted_c_busy", 32'(busy), 32'd0);
        dump_base = got.size();
        send_rx(8'h64);
        wait_idle("dumpC2", 1'b1);
        check_dump("dumpC2");

        // Reset in the middle of a dump, after the 7th byte.
        in_halt = 1'b0;
        dump_base = got.size();
        send_rx(8'h64);
        n = 0;
        while (got.size() - dump_base < 7 && n < BUDGET) begin
            tick();
            n++;
        end
        check("abort_reached7", 32'(got.size() - dump_base), 32'd7);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        n = got.size();
        repeat (5) tick();
        check("abort_no_tx", 32'(got.size() - n), 32'd0);
        rst = 1'b1;
        tick(); tick();
        fill_tables(1'b0);
        inPC = $urandom;
        dump_base = got.size();
        send_rx(8'h64);
        wait_idle("dumpD", 1'b0);
        check_dump("dumpD");

        // Reset cleared the halt latch; halt and pause together give one dump.
        fill_tables(1'b0);
        inPC = $urandom;
        dump_base = got.size();
        send_rx(8'h63);
        repeat (5) tick();
        check("run_after_reset", 32'(stop_debug), 32'd0);
        rx_data = 8'h70;
        rx_done = 1'b1;
        in_halt = 1'b1;
        tick();
        rx_done = 1'b0;
        in_halt = 1'b0;
        wait_idle("dumpE", 1'b1);
        check_dump("dumpE");
        n = got.size();
        repeat (40) tick();
        check("single_dump_no_tx", 32'(got.size() - n), 32'd0);
        check("single_dump_busy",  32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Sequencer between the UART debug link and the MIPS pipeline.
- Decodes single-byte host commands to run the pipeline continuously, step it one clock, or pause it.
- On each stop it freezes the pipeline and walks a fixed dump sequence over the UART transmitter: PC, stage latches via the latch mux, register file, then data memory.
- Sits inside the debug unit. It drives stop_debug, the latch-mux select and the debug read address.

Parameters:
NUM_LATCH, 40, number of 32-bit latch words selectable through outControlLatchMux (max 128)
NUM_REGS, 32, register-file words dumped
NUM_MEM, 32, data-memory words dumped (word index on outDebugAddress)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_done  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received command byte
in_halt  in  1  level, halt instruction has reached write-back
inPC  in  32  current PC
inLatch  in  32  latch word selected by outControlLatchMux
inFRData  in  32  register-file word at outDebugAddress[4:0]
inMemData  in  32  data-memory word at outDebugAddress
tx_done  in  1  one-cycle pulse, UART byte finished
tx_start  out  1  one-cycle pulse, send tx_data
tx_data  out  8  byte to transmit
stop_debug  out  1  1 = pipeline frozen
debug_on  out  1  1 = RF/memory read ports driven by outDebugAddress
outControlLatchMux  out  7  latch select
outDebugAddress  out  32  RF/memory debug address
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset (rst=0, async) drives the following; halted and the word/byte counters clear:
  - state=IDLE
  - stop_debug=1
  - tx_start=0, tx_data=0x00
  - debug_on=0
  - outControlLatchMux=0, outDebugAddress=0
  - busy=0
- States: IDLE, RUN, STEP, SELECT, SETTLE, SEND, WAIT_TX. All outputs are registered.
- IDLE accepts commands on rx_done:
  - 0x63 'c' -> RUN.
  - 0x73 's' -> STEP.
  - 0x64 'd' -> SELECT (dump without running).
  - Any other byte is ignored.
  - 'c' and 's' are ignored while halted=1; 'd' is always accepted.
- RUN: stop_debug=0 from the cycle after entry. Leaves on in_halt=1 or rx_done with 0x70 'p'.
  - On exit: stop_debug=1 at that edge, then -> SELECT.
  - in_halt also sets halted.
  - If in_halt and 'p' arrive in the same cycle, the result is a single dump.
- STEP: stop_debug=0 for exactly one cycle, then 1, then -> SELECT. If in_halt is seen during the step, halted is set.
- Dump sequence:
  - word 0 = inPC.
  - words 1..NUM_LATCH = inLatch with outControlLatchMux = k-1.
  - next NUM_REGS words = inFRData with debug_on=1 and outDebugAddress = 0..NUM_REGS-1.
  - next NUM_MEM words = inMemData with debug_on=1 and outDebugAddress = 0..NUM_MEM-1.
- Per-word timing:
  - SELECT drives select/address.
  - SETTLE waits 1 cycle, then captures the word into a 32-bit shift register.
  - SEND issues tx_start for 1 cycle with tx_data = current byte, MSB first.
  - WAIT_TX holds until tx_done, then goes to SEND for the next byte, or to SELECT for the next word after 4 bytes.
- Total bytes per dump = 4*(1+NUM_LATCH+NUM_REGS+NUM_MEM) = 420 with the defaults.
- After the last tx_done: debug_on=0, mux and address return to 0, state -> IDLE, stop_debug stays 1.
- tx_done outside WAIT_TX is ignored. rx_done outside IDLE/RUN is ignored.
- stop_debug=1 throughout every dump state.
- Reset mid-dump aborts immediately. No partial-byte completion is required.

Test Plan:
- Reset, then check outputs: stop_debug=1, busy=0, tx_start=0, outDebugAddress=0.
- In IDLE send 'd' with inPC=0x00400010, regs all 0x11111111 -> first 4 tx bytes 0x00,0x40,0x00,0x10. Exactly 420 tx_start pulses, then busy=0.
- Send 's' -> stop_debug low for exactly 1 clk, then a full dump. outControlLatchMux sweeps 0..39 and outDebugAddress sweeps 0..31 twice.
- Send 'c', raise in_halt after 50 clks -> stop_debug=1 on that edge and a dump follows. A subsequent 'c' is ignored (stop_debug stays 1); 'd' still dumps.
- Send 'c' then 'p' together with in_halt in the same cycle -> exactly one dump (420 bytes).
- Pulse rst low mid-dump after byte 7 -> outputs return to reset values asynchronously, no further tx_start; a new 'd' gives a complete 420-byte dump.
